// File: rtl/mem_data_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_data_responder_if
// Description : MEM-stage load/store bus between the pipeline (master) and
//               the data-memory responder (slave).
//   req_valid  - request present (load or store)
//   req_write  - 1 = store, 0 = load
//   req_addr   - byte address
//   req_wdata  - store data
//   req_ready  - responder is idle and can accept a request
//   stall      - pipeline must hold all stage registers this cycle
//   resp_valid - one-cycle response strobe
//   resp_rdata - load data during a load response, else 0
//   resp_err   - access fault flag during a response, else 0
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_data_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, stall, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, stall, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_data_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_data_responder
// Description : Multi-cycle data memory for the pipelined MIPS32 datapath.
//               Accepts one load/store at a time, stalls the pipeline for
//               LATENCY cycles and then returns a single-cycle response.
// Parameters  : DEPTH_WORDS - number of 32-bit words (power of two, >= 2)
//               LATENCY     - cycles from accept to response (1..15)
// Ports       : clk   - clock, rising edge
//               reset - asynchronous, active-low reset
//               bus   - mem_data_responder_if.slave (request/response bus)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_data_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 3
) (
  input  wire logic            clk,
  input  wire logic            reset,
  mem_data_responder_if.slave  bus
);

  localparam int         c_IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_LOAD_COUNT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  logic [3:0]           r_count;
  logic                 r_isWrite;
  logic                 r_fault;
  logic [c_IDX_W-1:0]   r_idx;
  logic [31:0]          r_wdata;
  logic                 r_reqReady;
  logic                 r_respValid;
  logic                 r_respErr;
  logic [31:0]          r_mem [DEPTH_WORDS];

  logic [c_IDX_W-1:0]   w_reqIdx;
  logic                 w_reqFault;
  logic                 w_commit;
  logic [31:0]          w_rdata;

  // Word index and fault decode of the incoming request.
  assign w_reqIdx   = bus.req_addr[c_IDX_W+1:2];
  assign w_reqFault = (bus.req_addr[1:0] != 2'b00) ||
                      ((bus.req_addr >> (c_IDX_W + 2)) != 32'd0);

  // A store lands in the array on the edge that leaves RESP, so a load
  // issued in the following IDLE cycle already sees the new data.
  assign w_commit = (r_state == S_RESP) && r_isWrite && !r_fault;

  // Load data is read combinationally from the array while responding.
  assign w_rdata = ((r_state == S_RESP) && !r_isWrite && !r_fault) ? r_mem[r_idx] : 32'd0;

  // ----------------------------------------------------------------------
  // Control FSM. r_count holds the number of edges still to go before
  // RESP; leaving WAIT coincides with it reaching zero, which places the
  // response LATENCY cycles after the accept cycle.
  // ----------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_count     <= 4'd0;
      r_isWrite   <= 1'b0;
      r_fault     <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= 32'd0;
      r_reqReady  <= 1'b1;
      r_respValid <= 1'b0;
      r_respErr   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_isWrite  <= bus.req_write;
            r_fault    <= w_reqFault;
            r_idx      <= w_reqIdx;
            r_wdata    <= bus.req_wdata;
            r_count    <= c_LOAD_COUNT;
            r_reqReady <= 1'b0;
            if (LATENCY == 1) begin
              r_state     <= S_RESP;
              r_respValid <= 1'b1;
              r_respErr   <= w_reqFault;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) begin
            r_state     <= S_RESP;
            r_respValid <= 1'b1;
            r_respErr   <= r_fault;
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_respValid <= 1'b0;
          r_respErr   <= 1'b0;
          r_reqReady  <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_count     <= 4'd0;
          r_respValid <= 1'b0;
          r_respErr   <= 1'b0;
          r_reqReady  <= 1'b1;
        end
      endcase
    end
  end

  // ----------------------------------------------------------------------
  // Word array. Reset clears every word, which also discards a store that
  // was still waiting for its commit edge.
  // ----------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (w_commit) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  // Stall covers the accept cycle and every WAIT cycle; it drops in RESP
  // so the pipeline captures the response on the RESP edge.
  assign bus.stall      = ((r_state == S_IDLE) && bus.req_valid) || (r_state == S_WAIT);
  assign bus.req_ready  = r_reqReady;
  assign bus.resp_valid = r_respValid;
  assign bus.resp_err   = r_respErr;
  assign bus.resp_rdata = w_rdata;

endmodule
`default_nettype wire
